// File: rtl/psum_mac_accum_if.sv
// psum_mac_accum_if
// Handshake and data bundle between the fetch logic, the partial-sum MAC
// block and the writeback path.
//   master : drives beats (in_*, data, weight) and clear requests (clr_req)
//   slave  : the MAC block; returns in_ready, clr_busy and the out_* result
// Widths follow the same parameters as the MAC block and must match it.
interface psum_mac_accum_if #(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 4,
    parameter int DW     = 16,
    parameter int AW     = 32,
    parameter int ADDR_W = 10
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_first;
    logic                      in_last;
    logic [ADDR_W-1:0]         in_addr;
    logic [N_IN*DW-1:0]        data;
    logic [N_OUT*N_IN*DW-1:0]  weight;
    logic                      clr_req;
    logic                      clr_busy;
    logic                      out_valid;
    logic [ADDR_W-1:0]         out_addr;
    logic [N_OUT*AW-1:0]       out_psum;

    modport master (
        output in_valid, in_first, in_last, in_addr, data, weight, clr_req,
        input  in_ready, clr_busy, out_valid, out_addr, out_psum
    );

    modport slave (
        input  in_valid, in_first, in_last, in_addr, data, weight, clr_req,
        output in_ready, clr_busy, out_valid, out_addr, out_psum
    );
endinterface

// File: rtl/psum_mac_accum.sv
// psum_mac_accum
// N_OUT lanes each form a signed N_IN-term dot product of one shared data
// vector against their own weight vector. Each lane result either overwrites
// (in_first) or is added into a per-address partial-sum buffer entry, with a
// fixed four-cycle latency and no bubbles for back-to-back address reuse.
// A clear request drains the pipeline and then zeroes the whole buffer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : psum_mac_accum_if.slave (beat handshake, clear, result)
// Build option:
//   PSUM_SAT_EN : when defined, the accumulate add saturates instead of
//                 wrapping (the adder tree always wraps).
module psum_mac_accum #(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 4,
    parameter int DW     = 16,
    parameter int AW     = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    psum_mac_accum_if.slave bus
);
    localparam int NODES = 2 * N_IN - 1;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t              state_q;
    logic                clrBusy_q;
    logic [ADDR_W-1:0]   clrCnt_q;

    logic                inReady;
    logic                accept;

    logic                s1Valid_q, s1First_q, s1Last_q;
    logic [ADDR_W-1:0]   s1Addr_q;
    logic signed [AW-1:0] prod_q [N_OUT][N_IN];
    logic signed [AW-1:0] prodComb [N_OUT][N_IN];

    logic                s2Valid_q, s2First_q, s2Last_q;
    logic [ADDR_W-1:0]   s2Addr_q;
    logic signed [AW-1:0] s2Sum_q [N_OUT];
    logic signed [AW-1:0] laneSum [N_OUT];

    logic                s3Valid_q, s3First_q, s3Last_q, s3Byp_q;
    logic [ADDR_W-1:0]   s3Addr_q;
    logic signed [AW-1:0] s3Sum_q [N_OUT];
    logic [N_OUT*AW-1:0] s3BypData_q;
    logic [N_OUT*AW-1:0] ramRd_q;

    logic                s4Valid_q, s4Last_q;
    logic [ADDR_W-1:0]   s4Addr_q;
    logic [N_OUT*AW-1:0] s4New_q;
    logic [N_OUT*AW-1:0] newVec;

    logic [N_OUT*AW-1:0] mem [DEPTH];
    logic                memWe;
    logic [ADDR_W-1:0]   memWaddr;
    logic [N_OUT*AW-1:0] memWdata;

    logic                outValid_q;
    logic [ADDR_W-1:0]   outAddr_q;
    logic [N_OUT*AW-1:0] outPsum_q;

    // A beat offered on the same edge as a clear request is refused so the
    // drain never has to chase a beat that arrived with the request.
    assign inReady      = !rst && !clrBusy_q && !bus.clr_req;
    assign accept       = bus.in_valid && inReady;
    assign bus.in_ready = inReady;
    assign bus.clr_busy = clrBusy_q;

    // Clear sequencer: wait for the four stages to empty, then sweep every
    // buffer entry to zero, one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clrBusy_q <= 1'b0;
            clrCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clr_req) begin
                        state_q   <= DRAIN;
                        clrBusy_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!(s1Valid_q || s2Valid_q || s3Valid_q || s4Valid_q)) begin
                        state_q  <= CLEAR;
                        clrCnt_q <= '0;
                    end
                end
                CLEAR: begin
                    if (clrCnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q   <= IDLE;
                        clrBusy_q <= 1'b0;
                    end else begin
                        clrCnt_q <= clrCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clrBusy_q <= 1'b0;
                end
            endcase
        end
    end

    // Full-precision signed products, sign-extended to the accumulator width.
    always_comb begin : products
        logic signed [2*DW-1:0] p;
        p = '0;
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                p = $signed(bus.data[i*DW +: DW]) * $signed(bus.weight[(k*N_IN+i)*DW +: DW]);
                prodComb[k][i] = AW'(p);
            end
        end
    end

    // Stage 1: capture the products of the accepted beat.
    always_ff @(posedge clk) begin
        s1Valid_q <= rst ? 1'b0 : accept;
        if (accept) begin
            s1First_q <= bus.in_first;
            s1Last_q  <= bus.in_last;
            s1Addr_q  <= bus.in_addr;
            for (int k = 0; k < N_OUT; k++) begin
                for (int i = 0; i < N_IN; i++) begin
                    prod_q[k][i] <= prodComb[k][i];
                end
            end
        end
    end

    // Binary adder tree per lane: leaves sit at node N_IN-1.., each parent
    // j sums children 2j+1 and 2j+2, root is node 0. Sums wrap modulo 2^AW.
    always_comb begin : adderTree
        logic signed [AW-1:0] node [NODES];
        for (int j = 0; j < NODES; j++) begin
            node[j] = '0;
        end
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                node[N_IN-1+i] = prod_q[k][i];
            end
            for (int j = N_IN - 2; j >= 0; j--) begin
                node[j] = node[2*j+1] + node[2*j+2];
            end
            laneSum[k] = node[0];
        end
    end

    // Stage 2 registers the lane sums; its address drives the buffer read.
    // Stage 3 captures the read data. The stage-4 beat writes on this same
    // edge and the RAM returns old data, so that write is captured as a
    // bypass alongside the read.
    always_ff @(posedge clk) begin
        s2Valid_q <= rst ? 1'b0 : s1Valid_q;
        s2First_q <= s1First_q;
        s2Last_q  <= s1Last_q;
        s2Addr_q  <= s1Addr_q;
        s2Sum_q   <= laneSum;
        s3Valid_q <= rst ? 1'b0 : s2Valid_q;
        s3First_q <= s2First_q;
        s3Last_q  <= s2Last_q;
        s3Addr_q  <= s2Addr_q;
        s3Sum_q   <= s2Sum_q;
        s3Byp_q     <= s4Valid_q && (s4Addr_q == s2Addr_q);
        s3BypData_q <= s4New_q;
        ramRd_q     <= mem[s2Addr_q];
    end

    // Combine: the newest matching value wins. The beat one ahead (still in
    // stage 4, not yet written) beats the one captured at read time, which
    // beats the RAM content.
    always_comb begin : combine
        logic [N_OUT*AW-1:0]  storedVec;
        logic signed [AW-1:0] stored;
        logic signed [AW-1:0] sumv;
        logic [AW:0]          wide;
        logic [AW-1:0]        accRes;
        newVec = '0;
        if (s4Valid_q && (s4Addr_q == s3Addr_q)) begin
            storedVec = s4New_q;
        end else if (s3Byp_q) begin
            storedVec = s3BypData_q;
        end else begin
            storedVec = ramRd_q;
        end
        for (int k = 0; k < N_OUT; k++) begin
            stored = storedVec[k*AW +: AW];
            sumv   = s3Sum_q[k];
            wide   = {stored[AW-1], stored} + {sumv[AW-1], sumv};
`ifdef PSUM_SAT_EN
            if (wide[AW] != wide[AW-1]) begin
                accRes = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end else begin
                accRes = wide[AW-1:0];
            end
`else
            accRes = wide[AW-1:0];
`endif
            newVec[k*AW +: AW] = s3First_q ? sumv : accRes;
        end
    end

    // Stage 4 holds the new entry value until it is written next edge.
    always_ff @(posedge clk) begin
        s4Valid_q <= rst ? 1'b0 : s3Valid_q;
        s4Last_q  <= s3Last_q;
        s4Addr_q  <= s3Addr_q;
        s4New_q   <= newVec;
    end

    // Single write port shared by the stage-4 write and the clear sweep;
    // the two never overlap because the sweep only starts once drained.
    assign memWe    = !rst && (s4Valid_q || (state_q == CLEAR));
    assign memWaddr = (state_q == CLEAR) ? clrCnt_q : s4Addr_q;
    assign memWdata = (state_q == CLEAR) ? '0 : s4New_q;

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWaddr] <= memWdata;
        end
    end

    // Result register: loaded only for last beats and pulsed for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outAddr_q  <= '0;
            outPsum_q  <= '0;
        end else begin
            outValid_q <= s4Valid_q && s4Last_q;
            if (s4Valid_q && s4Last_q) begin
                outAddr_q <= s4Addr_q;
                outPsum_q <= s4New_q;
            end
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_addr  = outAddr_q;
    assign bus.out_psum  = outPsum_q;
endmodule

// File: tb/tb_psum_mac_accum.sv
// tb_psum_mac_accum
// Directed and randomized beats against a sequential reference model of the
// partial-sum buffer: every accepted beat is applied to the model at once,
// and each last beat queues its expected result four cycles later.
module tb_psum_mac_accum;
    localparam int N_IN   = 16;
    localparam int N_OUT  = 4;
    localparam int DW     = 16;
    localparam int AW     = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    typedef struct {
        int                  due;
        logic [ADDR_W-1:0]   addr;
        logic [N_OUT*AW-1:0] psum;
    } exp_t;

    logic clk;
    logic rst;

    psum_mac_accum_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW), .ADDR_W(ADDR_W)) bus ();

    psum_mac_accum #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                checks = 0;
    int                errors = 0;
    int                cycle  = 0;
    logic [DW-1:0]     dataW [N_IN];
    logic [DW-1:0]     wW    [N_OUT][N_IN];
    logic [AW-1:0]     memM  [DEPTH][N_OUT];
    bit                known [DEPTH];
    logic              curFirst, curLast;
    logic [ADDR_W-1:0] curAddr;
    exp_t              expQ [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic f, input logic l, input logic [ADDR_W-1:0] a);
        curFirst = f;
        curLast  = l;
        curAddr  = a;
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_addr  = a;
        for (int i = 0; i < N_IN; i++) begin
            bus.data[i*DW +: DW] = dataW[i];
        end
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                bus.weight[(k*N_IN+i)*DW +: DW] = wW[k][i];
            end
        end
    endtask

    // Sequential semantics: dot product wrapped to AW bits, then overwrite
    // or add (wrapping, or clamping when saturation is built in).
    task automatic modelAccept();
        exp_t   e;
        longint maxV;
        longint minV;
        maxV   = (longint'(1) <<< (AW - 1)) - 1;
        minV   = -(longint'(1) <<< (AW - 1));
        e.psum = '0;
        for (int k = 0; k < N_OUT; k++) begin
            longint        s;
            longint        r;
            logic [AW-1:0] laneS;
            s = 0;
            for (int i = 0; i < N_IN; i++) begin
                s += longint'($signed(dataW[i])) * longint'($signed(wW[k][i]));
            end
            laneS = s[AW-1:0];
            if (curFirst) begin
                memM[curAddr][k] = laneS;
            end else begin
                r = longint'($signed(memM[curAddr][k])) + longint'($signed(laneS));
`ifdef PSUM_SAT_EN
                if (r > maxV) r = maxV;
                if (r < minV) r = minV;
`endif
                memM[curAddr][k] = r[AW-1:0];
            end
            e.psum[k*AW +: AW] = memM[curAddr][k];
        end
        known[curAddr] = 1'b1;
        if (curLast) begin
            e.due  = cycle + 4;
            e.addr = curAddr;
            expQ.push_back(e);
        end
    endtask

    // One clock: check the handshake before the edge, update the model on
    // the edge, then check the result registers just after it.
    task automatic tick();
        bit   acc;
        bit   clrAcc;
        exp_t e;
        bit   expV;
        @(negedge clk);
        checkOutput("in_ready", 128'(bus.in_ready), 128'(!rst && !bus.clr_req && !bus.clr_busy));
        acc    = bus.in_valid && !rst && !bus.clr_req && !bus.clr_busy;
        clrAcc = bus.clr_req && !rst && !bus.clr_busy;
        @(posedge clk);
        cycle++;
        if (rst) begin
            expQ.delete();
            for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
        end else begin
            if (acc) modelAccept();
            if (clrAcc) begin
                for (int a = 0; a < DEPTH; a++) begin
                    known[a] = 1'b1;
                    for (int k = 0; k < N_OUT; k++) memM[a][k] = '0;
                end
            end
        end
        #1;
        if (rst) begin
            checkOutput("rst_out_valid", 128'(bus.out_valid), 128'(0));
            checkOutput("rst_out_addr", 128'(bus.out_addr), 128'(0));
            checkOutput("rst_out_psum", 128'(bus.out_psum), 128'(0));
            checkOutput("rst_clr_busy", 128'(bus.clr_busy), 128'(0));
        end else begin
            expV = (expQ.size() > 0) && (expQ[0].due == cycle);
            checkOutput("out_valid", 128'(bus.out_valid), 128'(expV));
            if (expV) begin
                e = expQ.pop_front();
                checkOutput("out_addr", 128'(bus.out_addr), 128'(e.addr));
                checkOutput("out_psum", 128'(bus.out_psum), 128'(e.psum));
            end
        end
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (n) tick();
    endtask

    function automatic logic [DW-1:0] randVal();
        case ($urandom_range(0, 5))
            0:       return {1'b0, {(DW-1){1'b1}}};
            1:       return {1'b1, {(DW-1){1'b0}}};
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic randomBeat(input int addrSpan, input int firstPct);
        logic [ADDR_W-1:0] a;
        logic              f;
        a = ADDR_W'($urandom_range(0, addrSpan - 1));
        f = ($urandom_range(0, 99) < firstPct) || !known[a];
        for (int i = 0; i < N_IN; i++) dataW[i] = randVal();
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) wW[k][i] = randVal();
        end
        applyStimulus($urandom_range(0, 3) != 0, f, 1'($urandom_range(0, 1)), a);
    endtask

    task automatic setOnesVectors();
        for (int i = 0; i < N_IN; i++) dataW[i] = DW'(1);
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) wW[k][i] = DW'(k + 1);
        end
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        bus.clr_req = 1'b0;
        for (int i = 0; i < N_IN; i++) dataW[i] = '0;
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) wW[k][i] = '0;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("post_reset_ready", 128'(bus.in_ready), 128'(1));

        $display("[TB] single beat, all-ones data to addr 5");
        setOnesVectors();
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd5);
        tick();
        idle(6);

        $display("[TB] three back-to-back beats to addr 7");
        applyStimulus(1'b1, 1'b1, 1'b0, 10'd7);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd7);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 10'd7);
        tick();
        idle(6);

        $display("[TB] negative data, weights 2");
        for (int i = 0; i < N_IN; i++) dataW[i] = '1;
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) wW[k][i] = DW'(2);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd9);
        tick();
        idle(6);

        $display("[TB] random beats over a small address window");
        repeat (300) begin
            randomBeat(8, 50);
            tick();
        end
        idle(6);

        $display("[TB] clear with two beats in flight");
        setOnesVectors();
        applyStimulus(1'b1, 1'b1, 1'b0, 10'd3);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd3);
        tick();
        bus.clr_req = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 10'd3);
        tick();
        bus.clr_req = 1'b0;
        checkOutput("clr_busy_start", 128'(bus.clr_busy), 128'(1));
        n = 0;
        while (bus.clr_busy === 1'b1 && n < 1100) begin
            randomBeat(8, 50);
            tick();
            n++;
        end
        checkOutput("clr_busy_len", 128'(n >= 1025 && n <= 1030), 128'(1));

        for (int i = 0; i < N_IN; i++) dataW[i] = DW'(1);
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) wW[k][i] = (i == 0) ? DW'(10) : DW'(0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 10'd3);
        tick();
        idle(6);

        $display("[TB] random accumulation after clear");
        repeat (300) begin
            randomBeat(8, 20);
            tick();
        end
        idle(6);

        $display("[TB] reset with a last beat in flight");
        setOnesVectors();
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd12);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_ready", 128'(bus.in_ready), 128'(1));
        checkOutput("post_rst_clr_busy", 128'(bus.clr_busy), 128'(0));
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
